// File: rtl/snake_body_store.sv
// Snake body coordinate store: shifts on each move tick, grows on request, streams
// every entry as an index/coordinate pair and scans the streamed pairs for self-collision.
module snake_body_store #(
    parameter int SNAKE_LENGTH_BIT = 4,
    parameter int SNAKE_LENGTH_MAX = 16,
    parameter int INIT_LENGTH      = 2,
    parameter int INIT_X           = 10,
    parameter int INIT_Y           = 40
) (
    input  logic                        clock_25,
    input  logic                        reset,
    input  logic                        move_tick,
    input  logic                        grow,
    input  logic [6:0]                  snake_head_x,
    input  logic [6:0]                  snake_head_y,
    output logic [6:0]                  snake_body_x,
    output logic [6:0]                  snake_body_y,
    output logic [SNAKE_LENGTH_BIT-1:0] body_count,
    output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
    output logic                        self_hit
);

    localparam int DEPTH = SNAKE_LENGTH_MAX - 1;
    localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX = SNAKE_LENGTH_BIT'(DEPTH - 1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_MAX  = SNAKE_LENGTH_BIT'(DEPTH);

    logic [6:0]                  r_body_x [DEPTH];
    logic [6:0]                  r_body_y [DEPTH];
    logic                        r_scan_armed;
    logic [SNAKE_LENGTH_BIT-1:0] w_next_idx;

    assign w_next_idx = (body_count == LAST_IDX) ? '0 : body_count + 1'b1;

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i < INIT_LENGTH) begin
                    r_body_x[i] <= 7'(INIT_X - 1 - i);
                    r_body_y[i] <= 7'(INIT_Y);
                end else begin
                    r_body_x[i] <= '0;
                    r_body_y[i] <= '0;
                end
            end
            snake_length <= SNAKE_LENGTH_BIT'(INIT_LENGTH);
            body_count   <= '0;
            snake_body_x <= '0;
            snake_body_y <= '0;
            self_hit     <= 1'b0;
            r_scan_armed <= 1'b0;
        end else begin
            // The stream reads the pre-edge array, so the tick-edge pair is still pre-shift.
            body_count   <= w_next_idx;
            snake_body_x <= r_body_x[w_next_idx];
            snake_body_y <= r_body_y[w_next_idx];

            if (move_tick) begin
                r_body_x[0] <= snake_head_x;
                r_body_y[0] <= snake_head_y;
                for (int i = 1; i < DEPTH; i++) begin
                    r_body_x[i] <= r_body_x[i-1];
                    r_body_y[i] <= r_body_y[i-1];
                end
                if (grow && (snake_length < LEN_MAX)) begin
                    snake_length <= snake_length + 1'b1;
                end
                self_hit     <= 1'b0;
                r_scan_armed <= 1'b0;
            end else begin
                // Arming one edge late skips the stale pre-shift pair.
                r_scan_armed <= 1'b1;
                if (r_scan_armed && (body_count < snake_length) &&
                    (snake_body_x == snake_head_x) && (snake_body_y == snake_head_y)) begin
                    self_hit <= 1'b1;
                end
            end
        end
    end

endmodule
